// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard inputs from the pipeline and stall/flush controls back to it
//   inputs : id_rs, id_rt, id_uses_rt, ex_memread, ex_wreg, mem_branch, mem_zero, mem_jump,
//            dmem_req, dmem_ready
//   outputs: pc_en, pc_sel, ifid/idex/exmem/memwb_en, ifid/idex/exmem_flush, mem_err,
//            stall_cnt, flush_cnt
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0] id_rs, id_rt, ex_wreg;
  logic id_uses_rt, ex_memread, mem_branch, mem_zero, mem_jump, dmem_req, dmem_ready;
  logic pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  modport master (
    output id_rs, id_rt, id_uses_rt, ex_memread, ex_wreg, mem_branch, mem_zero, mem_jump,
           dmem_req, dmem_ready,
    input  pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           exmem_flush, mem_err, stall_cnt, flush_cnt
  );
  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_memread, ex_wreg, mem_branch, mem_zero, mem_jump,
           dmem_req, dmem_ready,
    output pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           exmem_flush, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for a 5-stage MIPS pipeline
//   clock_i : rising-edge clock
//   reset_i : synchronous active-low reset
//   hz_if   : hazard inputs and pipeline-register controls (slave side)
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W = 16
) (
  input logic clock_i,
  input logic reset_i,
  pipeline_hazard_ctrl_if.slave hz_if
);
  localparam int TW = $clog2(MEM_TIMEOUT) + 1;
  typedef enum logic [1:0] {RUN, MEMWAIT, ERROR} state_e;
  state_e state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic redirect, loaduse;
  logic [8:0] norm, ctl;
  assign redirect = (hz_if.mem_branch & hz_if.mem_zero) | hz_if.mem_jump;
  assign loaduse = hz_if.ex_memread & (hz_if.ex_wreg != 5'd0) &
                   ((hz_if.ex_wreg == hz_if.id_rs) | (hz_if.id_uses_rt & (hz_if.ex_wreg == hz_if.id_rt)));
  // ctl bits: pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, exmem_fl
  assign norm = redirect ? 9'b1_1_1111_111 : loaduse ? 9'b0_0_0111_010 : 9'b1_0_1111_000;
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    ctl = '0;
    case (state_q)
      RUN: begin
        if (hz_if.dmem_req & !hz_if.dmem_ready) begin
          state_d = MEMWAIT;
          timer_d = TW'(1);
        end else ctl = norm;
      end
      MEMWAIT: begin
        if (hz_if.dmem_ready) begin
          state_d = RUN;
          timer_d = '0;
          ctl = norm;
        end else begin
          timer_d = timer_q + TW'(1);
          state_d = (timer_q == TW'(MEM_TIMEOUT - 1)) ? ERROR : MEMWAIT;
        end
      end
      default: ;
    endcase
    if (!reset_i) ctl = '0;
  end
  // stalls are counted only while the sequencer is live; ERROR freezes the count
  assign stall_cnt_d = (!ctl[8] && state_q != ERROR && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  assign flush_cnt_d = (ctl[7] && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q <= RUN;
      timer_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign {hz_if.pc_en, hz_if.pc_sel, hz_if.ifid_en, hz_if.idex_en, hz_if.exmem_en, hz_if.memwb_en,
          hz_if.ifid_flush, hz_if.idex_flush, hz_if.exmem_flush} = ctl;
  assign hz_if.mem_err = (state_q == ERROR);
  assign hz_if.stall_cnt = stall_cnt_q;
  assign hz_if.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed self-checking bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=2)
module tb_pipeline_hazard_ctrl;
  localparam logic [8:0] ALL = 9'b1_0_1111_000;
  localparam logic [8:0] REDIR = 9'b1_1_1111_111;
  localparam logic [8:0] LU = 9'b0_0_0111_010;
  localparam logic [8:0] FROZ = 9'b0_0_0000_000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  logic [8:0] ctl;
  pipeline_hazard_ctrl_if #(.CNT_W(2)) hz ();
  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(2)) dut (.clock_i(clk), .reset_i(rst_n), .hz_if(hz));
  always #5 clk = ~clk;
  assign ctl = {hz.pc_en, hz.pc_sel, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en,
                hz.ifid_flush, hz.idex_flush, hz.exmem_flush};
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic ut, input logic mr,
                       input logic [4:0] wr, input logic br, input logic z, input logic j,
                       input logic rq, input logic rd);
    hz.id_rs = rs; hz.id_rt = rt; hz.id_uses_rt = ut; hz.ex_memread = mr; hz.ex_wreg = wr;
    hz.mem_branch = br; hz.mem_zero = z; hz.mem_jump = j; hz.dmem_req = rq; hz.dmem_ready = rd;
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    drive(8, 8, 1, 1, 8, 1, 1, 1, 1, 0);
    n_checks++; if (ctl !== FROZ) begin n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl, FROZ); end
    cyc();
    n_checks++; if (hz.stall_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_stall: got %0d want 0", hz.stall_cnt); end
    n_checks++; if (hz.flush_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_flush: got %0d want 0", hz.flush_cnt); end
    n_checks++; if (hz.mem_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", hz.mem_err); end
    cyc();
    n_checks++; if (hz.stall_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_hold_stall: got %0d want 0", hz.stall_cnt); end
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (ctl !== ALL) begin n_fail++; $display("FAIL reset_release: got %b want %b", ctl, ALL); end
  endtask
  task automatic test_loaduse();
    do_reset();
    drive(8, 0, 0, 1, 8, 0, 0, 0, 0, 0);
    n_checks++; if (ctl !== LU) begin n_fail++; $display("FAIL lu_rs: got %b want %b", ctl, LU); end
    cyc();
    n_checks++; if (hz.stall_cnt !== 2'd1) begin n_fail++; $display("FAIL lu_stall1: got %0d want 1", hz.stall_cnt); end
    drive(3, 8, 1, 1, 8, 0, 0, 0, 0, 0);
    n_checks++; if (ctl !== LU) begin n_fail++; $display("FAIL lu_rt: got %b want %b", ctl, LU); end
    cyc();
    drive(3, 8, 0, 1, 8, 0, 0, 0, 0, 0);
    n_checks++; if (ctl !== ALL) begin n_fail++; $display("FAIL lu_rt_unused: got %b want %b", ctl, ALL); end
    cyc();
    n_checks++; if (hz.stall_cnt !== 2'd2) begin n_fail++; $display("FAIL lu_stall2: got %0d want 2", hz.stall_cnt); end
    drive(8, 8, 1, 0, 8, 0, 0, 0, 0, 0);
    n_checks++; if (ctl !== ALL) begin n_fail++; $display("FAIL lu_no_load: got %b want %b", ctl, ALL); end
  endtask
  task automatic test_zero_reg();
    do_reset();
    drive(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    n_checks++; if (ctl !== ALL) begin n_fail++; $display("FAIL zero_reg: got %b want %b", ctl, ALL); end
    cyc();
    n_checks++; if (hz.stall_cnt !== 2'd0) begin n_fail++; $display("FAIL zero_reg_stall: got %0d want 0", hz.stall_cnt); end
  endtask
  task automatic test_redirect();
    do_reset();
    drive(8, 0, 0, 1, 8, 1, 1, 0, 0, 0);
    n_checks++; if (ctl !== REDIR) begin n_fail++; $display("FAIL br_taken: got %b want %b", ctl, REDIR); end
    cyc();
    n_checks++; if (hz.flush_cnt !== 2'd1) begin n_fail++; $display("FAIL br_flush_cnt: got %0d want 1", hz.flush_cnt); end
    n_checks++; if (hz.stall_cnt !== 2'd0) begin n_fail++; $display("FAIL br_stall_cnt: got %0d want 0", hz.stall_cnt); end
    drive(8, 0, 0, 1, 8, 1, 0, 0, 0, 0);
    n_checks++; if (ctl !== LU) begin n_fail++; $display("FAIL br_not_taken: got %b want %b", ctl, LU); end
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    n_checks++; if (ctl !== REDIR) begin n_fail++; $display("FAIL jump: got %b want %b", ctl, REDIR); end
    cyc();
    n_checks++; if (hz.flush_cnt !== 2'd2) begin n_fail++; $display("FAIL jump_flush_cnt: got %0d want 2", hz.flush_cnt); end
    n_checks++; if (hz.stall_cnt !== 2'd1) begin n_fail++; $display("FAIL jump_stall_cnt: got %0d want 1", hz.stall_cnt); end
  endtask
  task automatic test_memwait();
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    n_checks++; if (ctl !== ALL) begin n_fail++; $display("FAIL mem_hit: got %b want %b", ctl, ALL); end
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (ctl !== FROZ) begin n_fail++; $display("FAIL mem_frozen%0d: got %b want %b", i, ctl, FROZ); end
      cyc();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    n_checks++; if (ctl !== ALL) begin n_fail++; $display("FAIL mem_done: got %b want %b", ctl, ALL); end
    cyc();
    n_checks++; if (hz.stall_cnt !== 2'd3) begin n_fail++; $display("FAIL mem_stall_cnt: got %0d want 3", hz.stall_cnt); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (ctl !== ALL) begin n_fail++; $display("FAIL mem_back_run: got %b want %b", ctl, ALL); end
    n_checks++; if (hz.mem_err !== 1'b0) begin n_fail++; $display("FAIL mem_no_err: got %b want 0", hz.mem_err); end
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 1, 1, 0, 1, 1);
    n_checks++; if (ctl !== REDIR) begin n_fail++; $display("FAIL mem_done_redir: got %b want %b", ctl, REDIR); end
    cyc();
    n_checks++; if (hz.flush_cnt !== 2'd1) begin n_fail++; $display("FAIL mem_redir_cnt: got %0d want 1", hz.flush_cnt); end
  endtask
  task automatic test_timeout();
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc();
    n_checks++; if (hz.mem_err !== 1'b0) begin n_fail++; $display("FAIL to_early: got %b want 0", hz.mem_err); end
    cyc();
    n_checks++; if (hz.mem_err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b want 1", hz.mem_err); end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    n_checks++; if (ctl !== FROZ) begin n_fail++; $display("FAIL to_frozen: got %b want %b", ctl, FROZ); end
    cyc();
    n_checks++; if (hz.mem_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b want 1", hz.mem_err); end
    n_checks++; if (hz.flush_cnt !== 2'd0) begin n_fail++; $display("FAIL to_flush_cnt: got %0d want 0", hz.flush_cnt); end
    do_reset();
    n_checks++; if (hz.mem_err !== 1'b0) begin n_fail++; $display("FAIL to_reset_err: got %b want 0", hz.mem_err); end
  endtask
  task automatic test_reset_midwait();
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc();
    cyc();
    n_checks++; if (hz.stall_cnt !== 2'd2) begin n_fail++; $display("FAIL mw_stall_cnt: got %0d want 2", hz.stall_cnt); end
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    n_checks++; if (ctl !== FROZ) begin n_fail++; $display("FAIL mw_reset_ctl: got %b want %b", ctl, FROZ); end
    cyc();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (ctl !== ALL) begin n_fail++; $display("FAIL mw_reset_run: got %b want %b", ctl, ALL); end
    n_checks++; if (hz.stall_cnt !== 2'd0) begin n_fail++; $display("FAIL mw_reset_cnt: got %0d want 0", hz.stall_cnt); end
  endtask
  task automatic test_saturate();
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc();
    n_checks++; if (hz.flush_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_flush3: got %0d want 3", hz.flush_cnt); end
    cyc();
    cyc();
    n_checks++; if (hz.flush_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_flush_hold: got %0d want 3", hz.flush_cnt); end
    drive(8, 0, 0, 1, 8, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc();
    n_checks++; if (hz.stall_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_stall: got %0d want 3", hz.stall_cnt); end
  endtask
  initial begin
    test_reset();
    test_loaduse();
    test_zero_reg();
    test_redirect();
    test_memwait();
    test_timeout();
    test_reset_midwait();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
